// File: rtl/noise_gate.sv
`timescale 1ns/1ps
// Stereo downward expander / noise gate: peak envelope, 5-state FSM and a
// Q1.8 gain ramp applied over a two-stage per-frame pipeline.
module noise_gate #(
  parameter int          OPEN_THRESH  = 2000000,
  parameter int          CLOSE_THRESH = 1000000,
  parameter int unsigned HOLD_SAMPLES = 4800,
  parameter int unsigned ATTACK_STEP  = 16,
  parameter int unsigned RELEASE_STEP = 1,
  parameter int unsigned DECAY_SHIFT  = 10
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               enable,
  input  logic               sample_valid,
  input  logic signed [31:0] in_L,
  input  logic signed [31:0] in_R,
  output logic signed [31:0] out_L,
  output logic signed [31:0] out_R,
  output logic               out_valid,
  output logic               gate_open
);

  localparam int unsigned HW = $clog2(HOLD_SAMPLES + 1);

  typedef enum logic [2:0] {
    ST_CLOSED,
    ST_ATTACK,
    ST_OPEN,
    ST_HOLD,
    ST_RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic        [8:0]  gain_q, gain_d;
  logic signed [31:0] env_q, env_d;
  logic      [HW-1:0] hold_q, hold_d;
  logic signed [31:0] l_q, r_q;
  logic               v_q;
  logic signed [31:0] out_l_q, out_r_q, out_l_d, out_r_d;
  logic               ov_q, gate_q, gate_d;

  logic signed [31:0] mag_l, mag_r, peak, env_dec, env_new;
  logic        [9:0]  gain_up;
  logic signed [40:0] prod_l, prod_r;
  logic               unused_bits;

  // |-2^31| has no positive 32-bit form, so it saturates to 2^31-1
  function automatic logic signed [31:0] abs_sat(input logic signed [31:0] x);
    if (x == 32'sh8000_0000) return 32'sh7FFF_FFFF;
    return (x < 0) ? -x : x;
  endfunction

  always_comb begin
    mag_l   = abs_sat(l_q);
    mag_r   = abs_sat(r_q);
    peak    = (mag_l > mag_r) ? mag_l : mag_r;
    env_dec = env_q - (env_q >>> DECAY_SHIFT);
    env_new = (peak > env_dec) ? peak : env_dec;
    gain_up = {1'b0, gain_q} + 10'(ATTACK_STEP);

    prod_l  = $signed({{9{l_q[31]}}, l_q}) * $signed({32'd0, gain_q});
    prod_r  = $signed({{9{r_q[31]}}, r_q}) * $signed({32'd0, gain_q});
    out_l_d = enable ? prod_l[39:8] : l_q;
    out_r_d = enable ? prod_r[39:8] : r_q;
    unused_bits = ^{prod_l[40], prod_l[7:0], prod_r[40], prod_r[7:0]};
  end

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    env_d   = env_q;
    hold_d  = hold_q;
    if (!enable) begin
      state_d = ST_CLOSED;
      gain_d  = '0;
      env_d   = '0;
      hold_d  = '0;
    end else if (v_q) begin
      env_d = env_new;
      unique case (state_q)
        ST_CLOSED: if (env_new >= OPEN_THRESH) state_d = ST_ATTACK;
        ST_ATTACK: begin
          if (gain_up >= 10'd256) begin
            gain_d  = 9'd256;
            state_d = ST_OPEN;
          end else begin
            gain_d = gain_up[8:0];
          end
        end
        ST_OPEN: begin
          if (env_new < CLOSE_THRESH) begin
            state_d = ST_HOLD;
            hold_d  = HW'(HOLD_SAMPLES);
          end
        end
        ST_HOLD: begin
          if (env_new >= OPEN_THRESH)    state_d = ST_OPEN;
          else if (hold_q == HW'(1))     state_d = ST_RELEASE;
          else                           hold_d  = hold_q - HW'(1);
        end
        ST_RELEASE: begin
          if (env_new >= OPEN_THRESH) begin
            state_d = ST_ATTACK;
          end else if ({1'b0, gain_q} <= 10'(RELEASE_STEP)) begin
            gain_d  = '0;
            state_d = ST_CLOSED;
          end else begin
            gain_d = gain_q - 9'(RELEASE_STEP);
          end
        end
        default: state_d = ST_CLOSED;
      endcase
    end
    gate_d = (state_d == ST_OPEN) || (state_d == ST_HOLD);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      l_q     <= '0;
      r_q     <= '0;
      v_q     <= 1'b0;
      state_q <= ST_CLOSED;
      gain_q  <= '0;
      env_q   <= '0;
      hold_q  <= '0;
      out_l_q <= '0;
      out_r_q <= '0;
      ov_q    <= 1'b0;
      gate_q  <= 1'b0;
    end else begin
      v_q <= sample_valid;
      if (sample_valid) begin
        l_q <= in_L;
        r_q <= in_R;
      end
      state_q <= state_d;
      gain_q  <= gain_d;
      env_q   <= env_d;
      hold_q  <= hold_d;
      gate_q  <= gate_d;
      ov_q    <= v_q;
      if (v_q) begin
        out_l_q <= out_l_d;
        out_r_q <= out_r_d;
      end
    end
  end

  assign out_L     = out_l_q;
  assign out_R     = out_r_q;
  assign out_valid = ov_q;
  assign gate_open = gate_q;

endmodule

// File: tb/tb_noise_gate.sv
`timescale 1ns/1ps
// Scoreboard bench for noise_gate: a per-frame behavioural model predicts each
// output frame; a negedge monitor pops and compares on every out_valid.
module tb_noise_gate;

  localparam int OPEN_T  = 2000000;
  localparam int CLOSE_T = 1000000;
  localparam int HOLD_N  = 4;
  localparam int ATK     = 16;
  localparam int REL     = 64;
  localparam int DSH     = 2;

  logic clk = 1'b0;
  logic rst_n, en, sv;
  logic signed [31:0] il, ir;
  logic signed [31:0] out_l, out_r;
  logic ov, gopen;

  noise_gate #(
    .OPEN_THRESH (OPEN_T),
    .CLOSE_THRESH(CLOSE_T),
    .HOLD_SAMPLES(HOLD_N),
    .ATTACK_STEP (ATK),
    .RELEASE_STEP(REL),
    .DECAY_SHIFT (DSH)
  ) dut (
    .CLOCK_50    (clk),
    .resetn      (rst_n),
    .enable      (en),
    .sample_valid(sv),
    .in_L        (il),
    .in_R        (ir),
    .out_L       (out_l),
    .out_R       (out_r),
    .out_valid   (ov),
    .gate_open   (gopen)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [31:0] l;
    logic signed [31:0] r;
    logic               g;
    int unsigned        c;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural reference: gate "mode" as a name, envelope and gain as plain integers
  typedef enum int { M_SHUT, M_RISE, M_FULL, M_WAIT, M_FALL } mode_t;
  mode_t  m_mode;
  longint m_env;
  int     m_gain;
  int     m_hold;

  task automatic model_clear();
    m_mode = M_SHUT; m_env = 0; m_gain = 0; m_hold = 0;
  endtask

  function automatic longint mag(input logic signed [31:0] x);
    longint v = longint'(x);
    if (v < 0) v = -v;
    if (v > 64'sd2147483647) v = 64'sd2147483647;
    return v;
  endfunction

  task automatic model_frame(input logic signed [31:0] l, input logic signed [31:0] r,
                             input logic e, output exp_t x);
    longint pk, dec, envn;
    if (!e) begin
      x.l = l; x.r = r; x.g = 1'b0;
      model_clear();
      return;
    end
    pk   = (mag(l) > mag(r)) ? mag(l) : mag(r);
    dec  = m_env - (m_env / (64'sd1 << DSH));
    envn = (pk > dec) ? pk : dec;
    x.l  = 32'((longint'(l) * m_gain) >>> 8);
    x.r  = 32'((longint'(r) * m_gain) >>> 8);
    case (m_mode)
      M_SHUT: if (envn >= OPEN_T) m_mode = M_RISE;
      M_RISE: begin
        m_gain = (m_gain + ATK > 256) ? 256 : m_gain + ATK;
        if (m_gain == 256) m_mode = M_FULL;
      end
      M_FULL: if (envn < CLOSE_T) begin m_mode = M_WAIT; m_hold = HOLD_N; end
      M_WAIT: begin
        if (envn >= OPEN_T) m_mode = M_FULL;
        else if (m_hold == 1) m_mode = M_FALL;
        else m_hold--;
      end
      M_FALL: begin
        if (envn >= OPEN_T) m_mode = M_RISE;
        else begin
          m_gain = (m_gain - REL < 0) ? 0 : m_gain - REL;
          if (m_gain == 0) m_mode = M_SHUT;
        end
      end
      default: m_mode = M_SHUT;
    endcase
    m_env = envn;
    x.g = (m_mode == M_FULL) || (m_mode == M_WAIT);
  endtask

  // All stimulus is driven 1 time unit after a rising edge
  task automatic send(input logic signed [31:0] l, input logic signed [31:0] r, input int gap);
    exp_t x;
    il = l; ir = r; sv = 1'b1;
    model_frame(l, r, en, x);
    x.c = cyc;
    sbq.push_back(x);
    @(posedge clk); #1;
    sv = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_enable(input logic v);
    idle(3);
    en = v;
    if (!v) model_clear();
    idle(2);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (rst_n && ov) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        x = sbq.pop_front();
        chk("out_L", longint'(out_l), longint'(x.l));
        chk("out_R", longint'(out_r), longint'(x.r));
        chk("gate_open", longint'(gopen), longint'(x.g));
        chk("latency_cycle", longint'(cyc), longint'(x.c) + 2);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  logic signed [31:0] amp;
  int seg_len, cls;

  initial begin
    rst_n = 1'b0; en = 1'b1; sv = 1'b0; il = '0; ir = '0;
    model_clear();
    #1;
    chk("reset_out_L", longint'(out_l), 0);
    chk("reset_out_valid", longint'(ov), 0);
    chk("reset_gate_open", longint'(gopen), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // quiet input stays gated
    for (int i = 0; i < 200; i++) send(32'sd500000, 32'sd500000, int'($urandom_range(0, 2)));

    // attack ramp from closed, then open
    for (int i = 0; i < 22; i++) send(32'sd8000000, 32'sd8000000, 1);
    idle(4);

    // reset with a frame in flight while the gate is open
    send(32'sd8000000, -32'sd8000000, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_out_L", longint'(out_l), 0);
    chk("midreset_out_R", longint'(out_r), 0);
    chk("midreset_out_valid", longint'(ov), 0);
    chk("midreset_gate_open", longint'(gopen), 0);
    sbq.delete();
    model_clear();
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);

    // reopen, then hold/release and retrigger at gain 128
    for (int i = 0; i < 20; i++) send(32'sd8000000, 32'sd8000000, 0);
    for (int i = 0; i < 14; i++) send(32'sd0, 32'sd0, 0);
    for (int i = 0; i < 12; i++) send(32'sd8000000, -32'sd7000000, 0);
    for (int i = 0; i < 20; i++) send(32'sd0, 32'sd0, 1);
    idle(4);

    // bypass with extreme values back to back
    set_enable(1'b0);
    for (int i = 0; i < 10; i++) send(32'sh8000_0000, 32'sh7FFF_FFFF, 0);
    set_enable(1'b1);
    for (int i = 0; i < 20; i++) send(32'sd8000000, 32'sd8000000, 0);
    for (int i = 0; i < 3; i++) send(32'sh8000_0000, 32'sh7FFF_FFFF, 0);
    idle(4);

    // randomized segments of mixed amplitude classes and enable toggles
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 7) == 0) set_enable(1'($urandom_range(0, 3) != 0));
      seg_len = int'($urandom_range(5, 30));
      cls = int'($urandom_range(0, 3));
      for (int i = 0; i < seg_len; i++) begin
        case (cls)
          0: amp = 32'($urandom_range(0, 900000));
          1: amp = 32'($urandom_range(2000000, 32'h7FFF_FFFF));
          2: amp = 32'($urandom);
          default: amp = '0;
        endcase
        if ($urandom_range(0, 1) == 1) amp = -amp;
        send(amp, 32'($urandom_range(0, 1500000)), int'($urandom_range(0, 2)));
      end
    end
    set_enable(1'b1);

    for (int i = 0; i < 10 && sbq.size() != 0; i++) idle(1);
    chk("scoreboard_drained", longint'(sbq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
